// File: rtl/descrambler_stream.sv
// Streaming additive descrambler: an MSB-first LFSR keystream is XORed onto each accepted beat.
// The LFSR reseeds at every frame end, taken from tlast or from an internal beat counter.
module descrambler_stream #(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = 15,
  parameter logic [LFSR_W-1:0] SEED      = 15'b100111100011111,
  parameter logic [LFSR_W-1:0] TAP_MASK  = 15'b000000000000011,
  parameter int                FRAME_LEN = 255,
  parameter bit                USE_TLAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              descr_en,
  input  logic              s_axis_input_tvalid,
  output logic              s_axis_input_tready,
  input  logic [DATA_W-1:0] s_axis_input_tdata,
  input  logic              s_axis_input_tlast,
  output logic              m_axis_output_tvalid,
  input  logic              m_axis_output_tready,
  output logic [DATA_W-1:0] m_axis_output_tdata,
  output logic              m_axis_output_tlast,
  output logic              frame_len_err
);

  localparam int              CNT_W = 16;
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // s[LFSR_W] is the leftmost bit; s[1] is the next bit to leave the register.
  logic [LFSR_W:1]    lfsr_q, lfsr_d, lfsr_adv;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  keystream;
  logic               accept, at_len, frame_end, len_err;

  // A beat moves on a cycle where valid and ready are both high; the output
  // register may be refilled in the same cycle it drains, and nothing is accepted during reset.
  assign s_axis_input_tready = !reset && (!out_valid_q || m_axis_output_tready);
  assign accept              = s_axis_input_tvalid && s_axis_input_tready;

  always_comb begin
    lfsr_adv  = lfsr_q;
    keystream = '0;
    for (int n = 0; n < DATA_W; n++) begin
      keystream[DATA_W-1-n] = ^(lfsr_adv & TAP_MASK);
      lfsr_adv              = {keystream[DATA_W-1-n], lfsr_adv[LFSR_W:2]};
    end
  end

  assign at_len = (cnt_q == LEN);

  always_comb begin
    frame_end = at_len;
    len_err   = 1'b0;
    if (USE_TLAST) begin
      frame_end = s_axis_input_tlast;
      len_err   = (s_axis_input_tlast != at_len);
    end
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = s_axis_input_tdata ^ (descr_en ? keystream : '0);
      out_last_d  = frame_end;
      err_d       = len_err;
      if (frame_end) begin
        lfsr_d = SEED;
        cnt_d  = ONE;
      end else begin
        // A missing tlast at the nominal length wraps the count but keeps the keystream running.
        lfsr_d = lfsr_adv;
        cnt_d  = at_len ? ONE : cnt_q + ONE;
      end
    end else if (m_axis_output_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= SEED;
      cnt_q       <= ONE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign m_axis_output_tvalid = out_valid_q;
  assign m_axis_output_tdata  = out_data_q;
  assign m_axis_output_tlast  = out_last_q;
  assign frame_len_err        = err_q;

endmodule

// File: tb/tb_descrambler_stream.sv
// Bench for descrambler_stream: an 8-bit tlast-framed instance and a 16-bit counter-framed instance
// (FRAME_LEN=4), checked against hand-computed keystream bytes and a bit-serial keystream model.
module tb_descrambler_stream;
  localparam int W = 18;  // {data[15:0], tlast, frame_len_err}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_en, a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast, a_err;
  logic [7:0] a_s_tdata, a_m_tdata;
  logic        b_en, b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast, b_err;
  logic [15:0] b_s_tdata, b_m_tdata;

  descrambler_stream u_a (
    .clk(clk), .reset(reset), .descr_en(a_en),
    .s_axis_input_tvalid(a_s_tvalid), .s_axis_input_tready(a_s_tready),
    .s_axis_input_tdata(a_s_tdata), .s_axis_input_tlast(a_s_tlast),
    .m_axis_output_tvalid(a_m_tvalid), .m_axis_output_tready(a_m_tready),
    .m_axis_output_tdata(a_m_tdata), .m_axis_output_tlast(a_m_tlast),
    .frame_len_err(a_err)
  );

  descrambler_stream #(.DATA_W(16), .FRAME_LEN(4), .USE_TLAST(1'b0)) u_b (
    .clk(clk), .reset(reset), .descr_en(b_en),
    .s_axis_input_tvalid(b_s_tvalid), .s_axis_input_tready(b_s_tready),
    .s_axis_input_tdata(b_s_tdata), .s_axis_input_tlast(b_s_tlast),
    .m_axis_output_tvalid(b_m_tvalid), .m_axis_output_tready(b_m_tready),
    .m_axis_output_tdata(b_m_tdata), .m_axis_output_tlast(b_m_tlast),
    .frame_len_err(b_err)
  );

  typedef struct {
    logic [15:0] din;
    logic        last_in;
    logic        en;
    logic [15:0] dout;
    logic        last_out;
    logic        err;
  } vec_t;

  vec_t va[7];
  vec_t vb[6];

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic a_fresh      = 1'b1;
  logic b_fresh      = 1'b1;
  bit   rnd_ready    = 1'b0;
  logic x_bits[0:4095];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Keystream bit n is x[n+15] of the seed-started sequence x[i] = x[i-15] ^ x[i-14].
  function automatic logic [7:0] ks8(input int j);
    logic [7:0] r;
    for (int n = 0; n < 8; n++) r[7-n] = x_bits[8*j+15+n];
    return r;
  endfunction

  function automatic logic [15:0] ks16(input int j);
    logic [15:0] r;
    for (int n = 0; n < 16; n++) r[15-n] = x_bits[16*j+15+n];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      b_m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] want;
    if (reset) begin
      exp_a_q.delete();
      exp_b_q.delete();
      a_fresh = 1'b1;
      b_fresh = 1'b1;
    end else begin
      if (a_m_tvalid) begin
        if (exp_a_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL a_extra_beat: got data %h, expected no beat at %0t", a_m_tdata, $time);
        end else begin
          want = exp_a_q[0];
          if (!a_fresh) want[0] = 1'b0;
          check("a_out", 32'({8'h00, a_m_tdata, a_m_tlast, a_err}), 32'(want));
          if (a_m_tready) void'(exp_a_q.pop_front());
        end
      end
      a_fresh = !a_m_tvalid || a_m_tready;
      if (b_m_tvalid) begin
        if (exp_b_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL b_extra_beat: got data %h, expected no beat at %0t", b_m_tdata, $time);
        end else begin
          want = exp_b_q[0];
          if (!b_fresh) want[0] = 1'b0;
          check("b_out", 32'({b_m_tdata, b_m_tlast, b_err}), 32'(want));
          if (b_m_tready) void'(exp_b_q.pop_front());
        end
      end
      b_fresh = !b_m_tvalid || b_m_tready;
    end
  end

  task automatic send_a(input logic [7:0] d, input logic l, input logic en, input logic [W-1:0] e);
    int budget = 0;
    bit ok = 1'b0;
    a_s_tdata = d; a_s_tlast = l; a_en = en; a_s_tvalid = 1'b1;
    while (!ok && budget < 200) begin
      @(negedge clk);
      if (a_s_tready) ok = 1'b1;
      budget++;
    end
    if (ok) exp_a_q.push_back(e);
    else begin
      tests_run++;
      tests_failed++;
      $display("FAIL a_accept_timeout: got no tready, expected acceptance at %0t", $time);
    end
    @(posedge clk);
    #1;
    a_s_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic l, input logic en, input logic [W-1:0] e);
    int budget = 0;
    bit ok = 1'b0;
    b_s_tdata = d; b_s_tlast = l; b_en = en; b_s_tvalid = 1'b1;
    while (!ok && budget < 200) begin
      @(negedge clk);
      if (b_s_tready) ok = 1'b1;
      budget++;
    end
    if (ok) exp_b_q.push_back(e);
    else begin
      tests_run++;
      tests_failed++;
      $display("FAIL b_accept_timeout: got no tready, expected acceptance at %0t", $time);
    end
    @(posedge clk);
    #1;
    b_s_tvalid = 1'b0;
  endtask

  // Beats j = 1..nbeats of a frame starting on a fresh seed; tlast_at = 0 sends no tlast.
  task automatic frame_a(input int nbeats, input int tlast_at, input bit rnd_data, input bit gaps);
    logic [7:0] orig, din, dexp;
    logic       l_exp, e_exp;
    int         idx;
    for (int j = 1; j <= nbeats; j++) begin
      if (tlast_at != 0 && j > tlast_at) begin
        idx = j - tlast_at - 1; l_exp = 1'b0; e_exp = 1'b0;
      end else begin
        idx   = j - 1;
        l_exp = (j == tlast_at);
        e_exp = (tlast_at != 0) ? (j == tlast_at && tlast_at != 255) : (j == 255);
      end
      orig = 8'($urandom_range(0, 255));
      din  = rnd_data ? (orig ^ ks8(idx)) : 8'h00;
      dexp = rnd_data ? orig : ks8(idx);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_a(din, (j == tlast_at), 1'b1, {8'h00, dexp, l_exp, e_exp});
    end
  endtask

  task automatic frame_b(input int nbeats, input bit gaps);
    int p;
    for (int j = 1; j <= nbeats; j++) begin
      p = (j - 1) % 4;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_b(16'h0000, 1'($urandom_range(0, 1)), 1'b1, {ks16(p), (p == 3), 1'b0});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_a_left", exp_a_q.size(), 0);
    check("drain_b_left", exp_b_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [14:0] seed_v;
    seed_v = 15'b100111100011111;
    for (int i = 0; i < 15; i++) x_bits[i] = seed_v[i];
    for (int i = 15; i < 4096; i++) x_bits[i] = x_bits[i-15] ^ x_bits[i-14];

    // Beat 1 bypassed, then a short frame whose tlast on beat 5 is a length error.
    va[0] = '{16'h00A5, 1'b0, 1'b0, 16'h00A5, 1'b0, 1'b0};
    va[1] = '{16'h0000, 1'b0, 1'b1, 16'h0016, 1'b0, 1'b0};
    va[2] = '{16'h00FF, 1'b0, 1'b1, 16'h00C9, 1'b0, 1'b0};
    va[3] = '{16'h0074, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    va[4] = '{16'h0000, 1'b1, 1'b1, 16'h00B5, 1'b1, 1'b1};
    va[5] = '{16'h0000, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0};
    va[6] = '{16'h0000, 1'b0, 1'b1, 16'h0016, 1'b0, 1'b0};
    // Counter-framed 16-bit lane: input tlast must be ignored.
    vb[0] = '{16'h0000, 1'b0, 1'b1, 16'h0916, 1'b0, 1'b0};
    vb[1] = '{16'h0000, 1'b1, 1'b1, 16'h3674, 1'b0, 1'b0};
    vb[2] = '{16'h0000, 1'b0, 1'b1, 16'hB53B, 1'b0, 1'b0};
    vb[3] = '{16'h0000, 1'b0, 1'b1, ks16(3),  1'b1, 1'b0};
    vb[4] = '{16'h0000, 1'b1, 1'b1, 16'h0916, 1'b0, 1'b0};
    vb[5] = '{16'h0000, 1'b0, 1'b1, 16'h3674, 1'b0, 1'b0};

    reset = 1'b1;
    a_en = 1'b1; a_s_tvalid = 1'b0; a_s_tdata = '0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
    b_en = 1'b1; b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_tready", a_s_tready, 0);
    check("reset_a_tvalid", a_m_tvalid, 0);
    check("reset_a_tdata", a_m_tdata, 0);
    check("reset_a_tlast", a_m_tlast, 0);
    check("reset_a_err", a_err, 0);
    check("reset_b_tready", b_s_tready, 0);
    check("reset_b_tvalid", b_m_tvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("a_tready_after_reset", a_s_tready, 1);
    check("b_tready_after_reset", b_s_tready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      send_a(va[i].din[7:0], va[i].last_in, va[i].en, {8'h00, va[i].dout[7:0], va[i].last_out, va[i].err});
    drain();

    // Round trip on a full 255-beat frame with stalls, then a fresh frame of zeros.
    do_reset();
    rnd_ready = 1'b1;
    frame_a(255, 255, 1'b1, 1'b1);
    frame_a(4, 0, 1'b0, 1'b1);
    drain();
    rnd_ready = 1'b0;

    do_reset();
    frame_a(101, 100, 1'b0, 1'b0);
    drain();

    // No tlast at all: error at beat 255 and the keystream carries on.
    do_reset();
    rnd_ready = 1'b1;
    frame_a(300, 0, 1'b0, 1'b1);
    drain();
    rnd_ready = 1'b0;

    // Reset while beat 50 is offered mid-frame.
    do_reset();
    frame_a(49, 0, 1'b0, 1'b0);
    a_s_tvalid = 1'b1;
    a_s_tdata  = 8'h00;
    reset      = 1'b1;
    @(negedge clk);
    check("a_no_accept_in_reset", a_s_tready, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    a_s_tvalid = 1'b0;
    @(negedge clk);
    check("a_tvalid_after_mid_reset", a_m_tvalid, 0);
    @(posedge clk);
    #1;
    frame_a(2, 0, 1'b0, 1'b0);
    drain();

    do_reset();
    for (int i = 0; i < 6; i++)
      send_b(vb[i].din, vb[i].last_in, vb[i].en, {vb[i].dout, vb[i].last_out, vb[i].err});
    drain();
    do_reset();
    rnd_ready = 1'b1;
    frame_b(14, 1'b1);
    drain();
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish before %0t", $time);
    $fatal(1, "time limit");
  end
endmodule
